// File: rtl/clock_enable_generator.sv
// clock_enable_generator: lock-qualified, per-channel programmable clock-enable
// strobes derived from the system clock, with shadowed divide/phase registers.
//
// state | meaning
// HOLD  | lock not yet qualified; counters parked at 0, no strobes, configs apply at once
// RUN   | lock qualified (o_valid=1); counters run, configs apply at wrap or i_sync
module clock_enable_generator #(
  parameter int N_CHANNELS   = 3,
  parameter int DIV_WIDTH    = 8,
  parameter int DEFAULT_DIV  = 4,
  parameter int LOCK_CYCLES  = 16,
  parameter int CH_IDX_WIDTH = 2
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_locked,
  input  logic                    i_sync,
  input  logic                    i_cfg_write,
  input  logic [CH_IDX_WIDTH-1:0] i_cfg_channel,
  input  logic [DIV_WIDTH-1:0]    i_cfg_divide,
  input  logic [DIV_WIDTH-1:0]    i_cfg_phase,
  output logic                    o_cfg_error,
  output logic [N_CHANNELS-1:0]   o_pending,
  output logic [N_CHANNELS-1:0]   o_enable,
  output logic                    o_valid
);

  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_FULL = LOCK_W'(LOCK_CYCLES);
  localparam logic [CH_IDX_WIDTH:0] N_CH = (CH_IDX_WIDTH + 1)'(N_CHANNELS);
  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } run_state_t;

  run_state_t state_q, state_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;

  logic [DIV_WIDTH-1:0] cnt_q       [N_CHANNELS];
  logic [DIV_WIDTH-1:0] act_div_q   [N_CHANNELS];
  logic [DIV_WIDTH-1:0] act_phase_q [N_CHANNELS];
  logic [DIV_WIDTH-1:0] sh_div_q    [N_CHANNELS];
  logic [DIV_WIDTH-1:0] sh_phase_q  [N_CHANNELS];
  logic [DIV_WIDTH-1:0] div_m1      [N_CHANNELS];

  logic [N_CHANNELS-1:0] wrap;
  logic [N_CHANNELS-1:0] apply;
  logic [N_CHANNELS-1:0] wr_hit;
  logic                  wr_ok;
  logic [DIV_WIDTH-1:0]  wr_div_m1;
  logic [DIV_WIDTH-1:0]  wr_phase;

  assign o_valid = (state_q == RUN);

  // Lock filter: count consecutive locked cycles, saturating at LOCK_CYCLES.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (!i_locked) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q != LOCK_FULL) begin
      lock_cnt_d = lock_cnt_q + LOCK_W'(1);
    end
  end

  // Next run state: RUN exactly while the filtered lock count is saturated.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD:    if (lock_cnt_d == LOCK_FULL) state_d = RUN;
      RUN:     if (!i_locked) state_d = HOLD;
      default: state_d = HOLD;
    endcase
  end

  // State and lock counter registers.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q    <= HOLD;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Write decode and phase clamp against the incoming divide (0 behaves as 1).
  always_comb begin
    wr_ok     = i_cfg_write && ({1'b0, i_cfg_channel} < N_CH);
    wr_div_m1 = (i_cfg_divide == '0) ? '0 : i_cfg_divide - DIV_WIDTH'(1);
    wr_phase  = (i_cfg_phase > wr_div_m1) ? wr_div_m1 : i_cfg_phase;
  end

  // Per-channel wrap detection and shadow-apply conditions.
  always_comb begin
    wrap   = '0;
    apply  = '0;
    wr_hit = '0;
    for (int ch = 0; ch < N_CHANNELS; ch++) begin
      div_m1[ch] = (act_div_q[ch] == '0) ? '0 : act_div_q[ch] - DIV_WIDTH'(1);
      wrap[ch]   = (cnt_q[ch] == div_m1[ch]);
      apply[ch]  = o_pending[ch] && ((state_q == HOLD) || i_sync || wrap[ch]);
      wr_hit[ch] = wr_ok && (i_cfg_channel == CH_IDX_WIDTH'(ch));
    end
  end

  // Channel counters, strobes, active/shadow config and pending flags.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      o_cfg_error <= 1'b0;
      o_enable    <= '0;
      o_pending   <= '0;
      for (int ch = 0; ch < N_CHANNELS; ch++) begin
        cnt_q[ch]       <= '0;
        act_div_q[ch]   <= DIV_RST;
        act_phase_q[ch] <= '0;
        sh_div_q[ch]    <= DIV_RST;
        sh_phase_q[ch]  <= '0;
      end
    end else begin
      o_cfg_error <= i_cfg_write && !wr_ok;
      for (int ch = 0; ch < N_CHANNELS; ch++) begin
        if (state_q == RUN) begin
          o_enable[ch] <= !i_sync && (cnt_q[ch] == act_phase_q[ch]);
          cnt_q[ch]    <= (i_sync || wrap[ch]) ? '0 : cnt_q[ch] + DIV_WIDTH'(1);
        end else begin
          o_enable[ch] <= 1'b0;
          cnt_q[ch]    <= '0;
        end
        if (apply[ch]) begin
          act_div_q[ch]   <= sh_div_q[ch];
          act_phase_q[ch] <= sh_phase_q[ch];
        end
        // A write landing on an apply edge stays pending; the older shadow goes active.
        if (wr_hit[ch]) begin
          sh_div_q[ch]   <= i_cfg_divide;
          sh_phase_q[ch] <= wr_phase;
          o_pending[ch]  <= 1'b1;
        end else if (apply[ch]) begin
          o_pending[ch]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_enable_generator.sv
// Scoreboard bench for clock_enable_generator: the driver advances a
// behavioural model per edge and queues the expected outputs; a monitor
// compares them against the DUT one time step after each rising edge.
module tb_clock_enable_generator;

  localparam int N   = 3;
  localparam int DW  = 8;
  localparam int DEF = 4;
  localparam int LC  = 16;
  localparam int CW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, locked, sync, wr;
  logic [CW-1:0] ch;
  logic [DW-1:0] dv, ph;
  logic          err, valid;
  logic [N-1:0]  pend, en;

  clock_enable_generator #(
    .N_CHANNELS(N), .DIV_WIDTH(DW), .DEFAULT_DIV(DEF),
    .LOCK_CYCLES(LC), .CH_IDX_WIDTH(CW)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_locked(locked), .i_sync(sync),
    .i_cfg_write(wr), .i_cfg_channel(ch), .i_cfg_divide(dv), .i_cfg_phase(ph),
    .o_cfg_error(err), .o_pending(pend), .o_enable(en), .o_valid(valid)
  );

  typedef struct {
    logic         valid;
    logic [N-1:0] en;
    logic [N-1:0] pend;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each channel's position is (cycle - origin) mod divide,
  // where the origin moves whenever the channel is realigned.
  int cyc = 0;
  int t0[N];
  int a_div[N], a_ph[N], s_div[N], s_ph[N];
  bit m_pend[N];
  int streak = 0;
  bit m_valid = 1'b0;

  task automatic model_edge(bit r, bit l, bit s, bit w, int c, int d_in, int p_in);
    exp_t e;
    bit run;
    run = m_valid;
    e.en = '0;
    e.err = 1'b0;
    if (!r) begin
      for (int i = 0; i < N; i++) begin
        a_div[i] = DEF; a_ph[i] = 0; s_div[i] = DEF; s_ph[i] = 0;
        m_pend[i] = 1'b0; t0[i] = cyc + 1;
      end
      streak = 0;
      m_valid = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        int d, pos, dn;
        bit at_end, app;
        d = (a_div[i] < 1) ? 1 : a_div[i];
        pos = run ? (cyc - t0[i]) % d : 0;
        at_end = (pos == d - 1);
        app = m_pend[i] && (!run || s || at_end);
        e.en[i] = run && !s && (pos == a_ph[i]);
        if (!run || s || at_end) t0[i] = cyc + 1;
        if (app) begin
          a_div[i] = s_div[i];
          a_ph[i]  = s_ph[i];
        end
        if (w && c == i) begin
          dn = (d_in < 1) ? 1 : d_in;
          s_div[i] = d_in;
          s_ph[i]  = (p_in >= dn) ? dn - 1 : p_in;
          m_pend[i] = 1'b1;
        end else if (app) begin
          m_pend[i] = 1'b0;
        end
      end
      e.err = w && (c >= N);
      streak = l ? streak + 1 : 0;
      m_valid = (streak >= LC);
    end
    e.valid = m_valid;
    for (int i = 0; i < N; i++) e.pend[i] = m_pend[i];
    e.cyc = cyc;
    cyc++;
    exp_q.push_back(e);
  endtask

  task automatic drive(bit r, bit l, bit s, bit w, int c, int d_in, int p_in);
    @(negedge clk);
    rst_n = r; locked = l; sync = s; wr = w;
    ch = CW'(c); dv = DW'(d_in); ph = DW'(p_in);
    model_edge(r, l, s, w, c, d_in, p_in);
  endtask

  task automatic idle(int n, bit l);
    for (int k = 0; k < n; k++) drive(1'b1, l, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic write_cfg(int c, int d_in, int p_in);
    drive(1'b1, 1'b1, 1'b0, 1'b1, c, d_in, p_in);
  endtask

  task automatic chk(string nm, int at, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, at, act, expv);
    end
  endtask

  // Monitor: compare DUT outputs with the queued expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("o_valid",     e.cyc, 32'(valid), 32'(e.valid));
        chk("o_enable",    e.cyc, 32'(en),    32'(e.en));
        chk("o_pending",   e.cyc, 32'(pend),  32'(e.pend));
        chk("o_cfg_error", e.cyc, 32'(err),   32'(e.err));
      end
    end
  end

  initial begin
    rst_n = 1'b0; locked = 1'b0; sync = 1'b0; wr = 1'b0;
    ch = '0; dv = '0; ph = '0;

    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle(2, 1'b0);
    idle(30, 1'b1);

    // lock glitch restarts qualification
    idle(1, 1'b0);
    idle(10, 1'b1);
    idle(1, 1'b0);
    idle(25, 1'b1);

    write_cfg(1, 10, 3);
    idle(30, 1'b1);
    write_cfg(2, 5, 9);
    write_cfg(3, 7, 2);
    idle(25, 1'b1);

    write_cfg(0, 3, 0);
    write_cfg(1, 4, 1);
    write_cfg(2, 6, 2);
    idle(20, 1'b1);
    write_cfg(0, 5, 1);
    write_cfg(0, 7, 6);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0);
    idle(20, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2, 7, 1);
    idle(20, 1'b1);

    // reset mid-run with a pending write, then divide 0
    write_cfg(1, 9, 2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    idle(20, 1'b1);
    write_cfg(0, 0, 5);
    idle(12, 1'b1);
    idle(2, 1'b0);
    write_cfg(2, 3, 1);
    idle(20, 1'b1);

    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 511) != 0, $urandom_range(0, 63) != 0,
            $urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
            int'($urandom_range(0, 12)));
    end
    idle(5, 1'b1);

    @(posedge clk);
    #2;
    chk("queue_drain", cyc, 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clock_enable_generator.md
Name: clock_enable_generator

Overview:
Parametrised successor to the MMCM clock unit. It runs entirely on the system clock and derives N_CHANNELS programmable clock-enable strobes, each with its own runtime divide ratio and phase offset. It qualifies the MMCM lock signal with a stable-cycle filter before asserting o_valid. It sits between the clocking wizard's locked output and the ADC/DAC datapaths, which use the strobes as sampling/update enables instead of extra MMCM outputs.

Parameters:
N_CHANNELS, 3, number of independent enable channels (1..16)
DIV_WIDTH, 8, width of divide and phase fields
DEFAULT_DIV, 4, divide ratio loaded into every channel at reset (must be less than 2^DIV_WIDTH)
LOCK_CYCLES, 16, consecutive i_locked-high cycles required before o_valid asserts (at least 1)
CH_IDX_WIDTH, 2, width of channel select (must satisfy 2^CH_IDX_WIDTH >= N_CHANNELS)

Ports:
i_clock  in  1  system clock; all logic on rising edge
i_reset  in  1  synchronous reset, active-low
i_locked  in  1  MMCM locked, treated as already synchronous to i_clock
i_sync  in  1  one-cycle pulse: realign all channel counters
i_cfg_write  in  1  configuration write strobe
i_cfg_channel  in  CH_IDX_WIDTH  target channel for the write
i_cfg_divide  in  DIV_WIDTH  new divide ratio
i_cfg_phase  in  DIV_WIDTH  new phase offset
o_cfg_error  out  1  one-cycle pulse: write rejected because the channel index is at or above N_CHANNELS
o_pending  out  N_CHANNELS  per channel: shadow config written but not yet applied
o_enable  out  N_CHANNELS  per channel: one-cycle enable strobe
o_valid  out  1  lock qualified; enables are running

Behaviour:
- Reset (i_reset=0 at a clock edge) sets:
  - o_enable=0, o_valid=0, o_pending=0, o_cfg_error=0
  - all counters 0, lock counter 0
  - active and shadow divide = DEFAULT_DIV, phase = 0
- Reset overrides every other input in the same cycle.
- Lock filter:
  - lock_cnt increments while i_locked=1 and saturates at LOCK_CYCLES.
  - Any cycle with i_locked=0 clears lock_cnt; o_valid drops on the next edge.
  - o_valid=1 exactly when lock_cnt==LOCK_CYCLES, so it rises LOCK_CYCLES edges after i_locked rises.
- Run state, per channel, two states: HOLD (o_valid=0) and RUN (o_valid=1).
  - HOLD: counter forced to 0, o_enable=0.
  - HOLD to RUN happens for all channels in the same cycle, so they start phase-aligned.
- Counter rules:
  - Effective divide d = max(active_divide, 1).
  - cnt counts 0..d-1 and wraps to 0.
  - o_enable[ch] is registered: it is 1 in the cycle after cnt==active_phase.
  - Steady-state period is d cycles. Divide 0 or 1 gives o_enable continuously high in RUN.
- Phase clamp: at shadow-load time, a phase >= d is stored as d-1.
- Configuration writes:
  - A valid write loads the shadow registers and sets o_pending[ch] on the next edge.
  - Shadow is copied to active on the cycle cnt==d-1 (the wrap), or immediately if the channel is in HOLD; o_pending clears on that same edge.
  - A second write while pending overwrites the shadow; only the last write is applied.
  - A write and an apply on the same edge: the new write is kept pending and the old shadow is applied.
- Invalid channel index: no state changes; o_cfg_error pulses on the next edge.
- i_sync in RUN:
  - All counters go to 0 on the next edge.
  - All pending shadows apply on that edge.
  - o_enable for that edge is suppressed.
  - i_sync is ignored in HOLD.
- Lock loss mid-operation:
  - Enables stop the cycle after o_valid falls.
  - Pending configs stay pending and apply on entry to HOLD.
- Latency from o_valid rising to the first strobe on a channel with phase p: p+1 cycles.

Test Plan:
- Reset, then i_locked=1 held -> o_valid rises at the 16th edge after i_locked; ch0-2 first o_enable 1 cycle later (phase 0); period 4 cycles; all three strobes coincide.
- i_locked high 10 cycles, low 1, high again -> o_valid stays 0 until 16 further consecutive high cycles.
- In RUN, write ch1 divide=10 phase=3 -> o_pending[1]=1 until ch1 wrap; afterwards o_enable[1] period 10, asserting the cycle after cnt==3; ch0 and ch2 unchanged.
- Write ch2 divide=5 phase=9 -> phase clamped to 4; write ch3 (N_CHANNELS=3) -> o_cfg_error pulses once, no o_pending change.
- Channels with divides 3/4/6 in RUN, pulse i_sync -> all counters 0 next edge; no strobe that edge; strobes realigned; pending configs cleared.
- Drop i_reset mid-RUN with a pending write -> all outputs 0 next edge; divides back to 4; pending discarded; divide 0 written later behaves as divide 1 (enable constantly high).
